// File: rtl/sincos_sched_if.sv
// Bundle of the requester-side handshake and the sine-unit side of sincos_sched.
// slave  : the scheduler itself.
// master : whoever drives requests and hosts the sine unit.
interface sincos_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic                 en;
  logic [NREQ-1:0]      req;
  logic [27*NREQ-1:0]   req_angle;
  logic [NREQ-1:0]      req_cos;
  logic [NREQ-1:0]      gnt;
  logic                 trig_en;
  logic [26:0]          trig_angle;
  logic [26:0]          trig_result;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [26:0]          rsp_data;
  logic [NREQ-1:0]      busy;

  modport slave (
    input  en, req, req_angle, req_cos, trig_result,
    output gnt, trig_en, trig_angle, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output en, req, req_angle, req_cos, trig_result,
    input  gnt, trig_en, trig_angle, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/sincos_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined sine unit among
// NREQ requesters. Cos requests are turned into sine by adding PI/2 (402 in
// 8-fractional-bit units). Each issue is tagged with the requester ID so the
// result can be routed back TRIG_LAT+1 enabled edges later.
// Optional build macro: SINCOS_RANGE_REDUCE_EN folds the issued angle into
// [-PI, PI] with a single +/-2PI step; without it the angle passes through.
module sincos_sched #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int TRIG_LAT = 4
) (
  input logic           clk,
  input logic           reset_n,
  sincos_sched_if.slave bus
);
  localparam logic [26:0] HALF_PI = 27'd402;
`ifdef SINCOS_RANGE_REDUCE_EN
  localparam logic signed [26:0] PI_S   = 27'sd804;
  localparam logic [26:0]        TWO_PI = 27'd1608;
`endif

  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt_vec;
  logic [NREQ-1:0] busy_q;
  logic [NREQ-1:0] busy_nxt;
  logic [IDW:0]    scan_w;
  logic [IDW-1:0]  scan_idx;
  logic [26:0]     sel_angle;
  logic [26:0]     sum_angle;
  logic [26:0]     red_angle;
  logic [26:0]     trig_angle_q;
  logic [TRIG_LAT:0] tag_v_q;
  logic [IDW-1:0]  tag_id_q [TRIG_LAT+1];
  logic            tag_out_v;
  logic [IDW-1:0]  tag_out_id;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [26:0]     rsp_data_q;

  assign tag_out_v  = tag_v_q[TRIG_LAT];
  assign tag_out_id = tag_id_q[TRIG_LAT];

  // Pick the first eligible requester at or after the pointer, wrapping.
  // Grant is forced low while reset is asserted so nothing leaks out.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    gnt_vec  = '0;
    scan_w   = '0;
    scan_idx = '0;
    elig     = bus.req & ~busy_q & {NREQ{bus.en}};
    for (int k = 0; k < NREQ; k++) begin
      scan_w = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_w >= (IDW+1)'(NREQ)) scan_w = scan_w - (IDW+1)'(NREQ);
      scan_idx = scan_w[IDW-1:0];
      if (!gnt_any && elig[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_idx;
      end
    end
    if (!reset_n) begin
      gnt_any = 1'b0;
      gnt_id  = '0;
    end
    if (gnt_any) gnt_vec[gnt_id] = 1'b1;
  end

  // Angle of the granted requester, cos phase shift, optional single-step wrap.
  always_comb begin
    sel_angle = bus.req_angle[gnt_id*27 +: 27];
    sum_angle = sel_angle + (bus.req_cos[gnt_id] ? HALF_PI : 27'd0);
`ifdef SINCOS_RANGE_REDUCE_EN
    if ($signed(sum_angle) > PI_S)       red_angle = sum_angle - TWO_PI;
    else if ($signed(sum_angle) < -PI_S) red_angle = sum_angle + TWO_PI;
    else                                 red_angle = sum_angle;
`else
    red_angle = sum_angle;
`endif
  end

  // Busy: release when the tag retires, claim on grant (never the same ID).
  always_comb begin
    busy_nxt = busy_q;
    if (tag_out_v) busy_nxt[tag_out_id] = 1'b0;
    if (gnt_any)   busy_nxt[gnt_id]     = 1'b1;
  end

  // Issue register, tag pipeline, busy and response; all frozen while en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      trig_angle_q <= '0;
      tag_v_q      <= '0;
      busy_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      for (int k = 0; k <= TRIG_LAT; k++) tag_id_q[k] <= '0;
    end else if (bus.en) begin
      if (gnt_any) begin
        ptr_q        <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
        trig_angle_q <= red_angle;
      end
      tag_v_q     <= {tag_v_q[TRIG_LAT-1:0], gnt_any};
      tag_id_q[0] <= gnt_id;
      for (int k = 1; k <= TRIG_LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
      busy_q      <= busy_nxt;
      rsp_valid_q <= tag_out_v;
      if (tag_out_v) begin
        rsp_id_q   <= tag_out_id;
        rsp_data_q <= bus.trig_result;
      end
    end else begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.gnt        = gnt_vec;
  assign bus.trig_en    = bus.en;
  assign bus.trig_angle = trig_angle_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = busy_q;
endmodule
